seg_counter_display: RTL and testbench

Parametrised up/down counter with a time-multiplexed, active-low seven-segment driver. It generalises the fixed 4-bit display counter to N digits, binary-hex or BCD counting, a programmable step rate, synchronous load, direction control and a wrap flag. It sits between board clock/switch inputs and the anode/cathode pins of the display.

---
 rtl/seg_display_pkg.sv | 40 ++++
 rtl/seg7_decoder.sv | 32 +++
 rtl/seg_counter_display.sv | 144 ++++++++++++++
 tb/tb_seg_counter_display.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_display_pkg.sv
// Segment patterns and BCD digit arithmetic shared by the counter/display block.
// Patterns are active-low, ordered {dp,g,f,e,d,c,b,a}; dp is always off.
package seg_display_pkg;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_A     = 8'h88;
    localparam logic [7:0] SEG_B     = 8'h83;
    localparam logic [7:0] SEG_C     = 8'hC6;
    localparam logic [7:0] SEG_D     = 8'hA1;
    localparam logic [7:0] SEG_E     = 8'h86;
    localparam logic [7:0] SEG_F     = 8'h8E;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Returns {carry_out, digit}; carry_out doubles as the borrow when counting down.
    function automatic logic [4:0] bcd_digit_step(
        input logic [3:0] i_digit,
        input logic       i_up,
        input logic       i_cin
    );
        logic [4:0] w_res;
        w_res = {1'b0, i_digit};
        if (i_cin) begin
            if (i_up)
                w_res = (i_digit >= 4'd9) ? {1'b1, 4'd0} : {1'b0, i_digit + 4'd1};
            else
                w_res = (i_digit == 4'd0) ? {1'b1, 4'd9} : {1'b0, i_digit - 4'd1};
        end
        return w_res;
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational nibble to active-low seven-segment pattern decoder.
module seg7_decoder
    import seg_display_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [7:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        case (i_nibble)
            4'h0: o_seg = SEG_0;
            4'h1: o_seg = SEG_1;
            4'h2: o_seg = SEG_2;
            4'h3: o_seg = SEG_3;
            4'h4: o_seg = SEG_4;
            4'h5: o_seg = SEG_5;
            4'h6: o_seg = SEG_6;
            4'h7: o_seg = SEG_7;
            4'h8: o_seg = SEG_8;
            4'h9: o_seg = SEG_9;
            4'hA: o_seg = SEG_A;
            4'hB: o_seg = SEG_B;
            4'hC: o_seg = SEG_C;
            4'hD: o_seg = SEG_D;
            4'hE: o_seg = SEG_E;
            4'hF: o_seg = SEG_F;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_counter_display.sv
// N-digit up/down counter (binary or BCD) with prescaled stepping, load and wrap pulse,
// driving a time-multiplexed active-low seven-segment display.
module seg_counter_display
    import seg_display_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int BCD      = 0,
    parameter int TICK_DIV = 50_000_000,
    parameter int SCAN_DIV = 100_000
) (
    input  logic                  clk,
    input  logic                  switch,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count,
    output logic                  wrap,
    output logic [DIGITS-1:0]     anode,
    output logic [7:0]            cathode
);

    localparam int W  = 4 * DIGITS;
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

    logic [TW-1:0]     r_tick_cnt;
    logic [SW-1:0]     r_scan_cnt;
    logic [IW-1:0]     r_idx;
    logic [W-1:0]      r_count;
    logic              r_wrap;
    logic [DIGITS-1:0] r_anode;
    logic [7:0]        r_cathode;

    logic              w_step;
    logic [W-1:0]      w_bin_next;
    logic              w_bin_wrap;
    logic [W-1:0]      w_bcd_next;
    logic              w_bcd_wrap;
    logic [W-1:0]      w_count_next;
    logic              w_wrap_next;
    logic [W-1:0]      w_load_val;
    logic [3:0]        w_nibble;
    logic [7:0]        w_seg;

    assign w_step = en && (r_tick_cnt == TICK_LAST);

    assign w_bin_next = up ? (r_count + W'(1)) : (r_count - W'(1));
    assign w_bin_wrap = up ? (&r_count) : ~(|r_count);

    // Decimal ripple: the carry out of the top digit is exactly the wrap condition.
    always_comb begin
        logic       w_carry;
        logic [4:0] w_res;
        w_carry    = 1'b1;
        w_res      = '0;
        w_bcd_next = '0;
        for (int i = 0; i < DIGITS; i++) begin
            w_res                 = bcd_digit_step(r_count[4*i +: 4], up, w_carry);
            w_bcd_next[4*i +: 4]  = w_res[3:0];
            w_carry               = w_res[4];
        end
        w_bcd_wrap = w_carry;
    end

    assign w_count_next = (BCD != 0) ? w_bcd_next : w_bin_next;
    assign w_wrap_next  = (BCD != 0) ? w_bcd_wrap : w_bin_wrap;

    always_comb begin
        w_load_val = load_val;
        if (BCD != 0) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (load_val[4*i +: 4] > 4'd9)
                    w_load_val[4*i +: 4] = 4'd9;
            end
        end
    end

    always_ff @(posedge clk or negedge switch) begin
        if (!switch) begin
            r_tick_cnt <= '0;
            r_count    <= '0;
            r_wrap     <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            if (load) begin
                r_count    <= w_load_val;
                r_tick_cnt <= '0;
            end else if (w_step) begin
                r_count    <= w_count_next;
                r_wrap     <= w_wrap_next;
                r_tick_cnt <= '0;
            end else if (en) begin
                r_tick_cnt <= r_tick_cnt + TW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge switch) begin
        if (!switch) begin
            r_scan_cnt <= '0;
            r_idx      <= '0;
        end else if (r_scan_cnt == SCAN_LAST) begin
            r_scan_cnt <= '0;
            r_idx      <= (r_idx == IDX_LAST) ? '0 : r_idx + IW'(1);
        end else begin
            r_scan_cnt <= r_scan_cnt + SW'(1);
        end
    end

    always_comb begin
        w_nibble = r_count[3:0];
        for (int i = 0; i < DIGITS; i++) begin
            if (r_idx == IW'(i))
                w_nibble = r_count[4*i +: 4];
        end
    end

    seg7_decoder u_dec (
        .i_nibble (w_nibble),
        .o_seg    (w_seg)
    );

    always_ff @(posedge clk or negedge switch) begin
        if (!switch) begin
            r_anode   <= '1;
            r_cathode <= SEG_BLANK;
        end else begin
            r_anode   <= ~(DIGITS'(1) << r_idx);
            r_cathode <= w_seg;
        end
    end

    assign count   = r_count;
    assign wrap    = r_wrap;
    assign anode   = r_anode;
    assign cathode = r_cathode;

endmodule

// File: tb/tb_seg_counter_display.sv
// Bench for seg_counter_display: a binary and a BCD instance checked every cycle
// against an integer-arithmetic model, plus directed literal expectations.
module tb_seg_counter_display;

    localparam int DIGITS   = 4;
    localparam int TICK_DIV = 4;
    localparam int SCAN_DIV = 2;

    logic        clk = 1'b0;
    logic        switch;
    logic        en_v   [2];
    logic        up_v   [2];
    logic        load_v [2];
    logic [15:0] lv     [2];
    logic [15:0] cnt_o  [2];
    logic        wrap_o [2];
    logic [3:0]  an_o   [2];
    logic [7:0]  cat_o  [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seg_counter_display #(.DIGITS(DIGITS), .BCD(0), .TICK_DIV(TICK_DIV), .SCAN_DIV(SCAN_DIV)) u_bin (
        .clk(clk), .switch(switch), .en(en_v[0]), .up(up_v[0]), .load(load_v[0]),
        .load_val(lv[0]), .count(cnt_o[0]), .wrap(wrap_o[0]), .anode(an_o[0]), .cathode(cat_o[0])
    );

    seg_counter_display #(.DIGITS(DIGITS), .BCD(1), .TICK_DIV(TICK_DIV), .SCAN_DIV(SCAN_DIV)) u_bcd (
        .clk(clk), .switch(switch), .en(en_v[1]), .up(up_v[1]), .load(load_v[1]),
        .load_val(lv[1]), .count(cnt_o[1]), .wrap(wrap_o[1]), .anode(an_o[1]), .cathode(cat_o[1])
    );

    logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int bcd2int(input int v);
        int r = 0;
        int p = 1;
        for (int i = 0; i < 4; i++) begin
            r += ((v >> (4*i)) & 15) * p;
            p *= 10;
        end
        return r;
    endfunction

    function automatic int int2bcd(input int d);
        int r = 0;
        int x = d;
        for (int i = 0; i < 4; i++) begin
            r |= (x % 10) << (4*i);
            x /= 10;
        end
        return r;
    endfunction

    function automatic int clamp_bcd(input int v);
        int r = 0;
        int n;
        for (int i = 0; i < 4; i++) begin
            n = (v >> (4*i)) & 15;
            if (n > 9) n = 9;
            r |= n << (4*i);
        end
        return r;
    endfunction

    function automatic int model_step(input int v, input bit bcd, input bit dir_up, output bit wr);
        int d;
        if (bcd) begin
            d = bcd2int(v);
            if (dir_up) begin wr = (d == 9999); d = (d + 1) % 10000; end
            else        begin wr = (d == 0);    d = (d + 9999) % 10000; end
            return int2bcd(d);
        end
        if (dir_up) begin wr = (v == 65535); return (v + 1) % 65536; end
        wr = (v == 0);
        return (v + 65535) % 65536;
    endfunction

    // Model state, one slot per instance (0 = binary, 1 = BCD)
    int         m_cnt  [2] = '{0, 0};
    int         m_tick [2] = '{0, 0};
    int         m_scan [2] = '{0, 0};
    int         m_idx  [2] = '{0, 0};
    bit         m_wrap [2] = '{0, 0};
    logic [3:0] m_an   [2] = '{4'hF, 4'hF};
    logic [7:0] m_cat  [2] = '{8'hFF, 8'hFF};

    always @(posedge clk or negedge switch) begin
        bit w;
        for (int k = 0; k < 2; k++) begin
            if (!switch) begin
                m_cnt[k] = 0; m_tick[k] = 0; m_scan[k] = 0; m_idx[k] = 0;
                m_wrap[k] = 0; m_an[k] = 4'hF; m_cat[k] = 8'hFF;
            end else begin
                m_an[k]  = ~(4'b0001 << m_idx[k]);
                m_cat[k] = seg_tab[(m_cnt[k] >> (4*m_idx[k])) & 15];
                if (m_scan[k] == SCAN_DIV-1) begin
                    m_scan[k] = 0;
                    m_idx[k]  = (m_idx[k] + 1) % DIGITS;
                end else begin
                    m_scan[k]++;
                end
                m_wrap[k] = 0;
                if (load_v[k]) begin
                    m_cnt[k]  = (k == 1) ? clamp_bcd(int'(lv[k])) : int'(lv[k]);
                    m_tick[k] = 0;
                end else if (en_v[k]) begin
                    if (m_tick[k] == TICK_DIV-1) begin
                        m_tick[k] = 0;
                        m_cnt[k]  = model_step(m_cnt[k], k == 1, up_v[k], w);
                        m_wrap[k] = w;
                    end else begin
                        m_tick[k]++;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            check($sformatf("u%0d count", k),   32'(cnt_o[k]),  32'(m_cnt[k]));
            check($sformatf("u%0d wrap", k),    32'(wrap_o[k]), 32'(m_wrap[k]));
            check($sformatf("u%0d anode", k),   32'(an_o[k]),   32'(m_an[k]));
            check($sformatf("u%0d cathode", k), 32'(cat_o[k]),  32'(m_cat[k]));
        end
    end

    task automatic wait_cnt(input int k, input logic [15:0] v, input string nm);
        int n = 0;
        while (cnt_o[k] !== v && n < 40) begin
            @(negedge clk);
            n++;
        end
        check(nm, 32'(cnt_o[k]), 32'(v));
    endtask

    initial begin
        logic [3:0] seen;
        switch = 1'b1;
        for (int k = 0; k < 2; k++) begin
            en_v[k] = 1'b0; up_v[k] = 1'b1; load_v[k] = 1'b0; lv[k] = '0;
        end
        #1 switch = 1'b0;
        repeat (3) @(negedge clk);
        check("rst count",   32'(cnt_o[0]), 32'h0);
        check("rst wrap",    32'(wrap_o[0]), 32'h0);
        check("rst anode",   32'(an_o[0]),  32'hF);
        check("rst cathode", 32'(cat_o[0]), 32'hFF);

        // Release and count 0 -> 1 -> 2
        switch  = 1'b1;
        en_v[0] = 1'b1;
        @(negedge clk);
        check("first anode",   32'(an_o[0]),  32'hE);
        check("first cathode", 32'(cat_o[0]), 32'hC0);
        repeat (2) @(negedge clk);
        check("count before step", 32'(cnt_o[0]), 32'h0);
        @(negedge clk);
        check("count step1", 32'(cnt_o[0]), 32'h1);
        repeat (3) @(negedge clk);
        check("count hold1", 32'(cnt_o[0]), 32'h1);
        @(negedge clk);
        check("count step2", 32'(cnt_o[0]), 32'h2);

        // Binary wrap up then down
        load_v[0] = 1'b1; lv[0] = 16'hFFFE;
        @(negedge clk);
        load_v[0] = 1'b0;
        check("load FFFE", 32'(cnt_o[0]), 32'hFFFE);
        check("load no wrap", 32'(wrap_o[0]), 32'h0);
        wait_cnt(0, 16'hFFFF, "bin to FFFF");
        check("FFFF no wrap", 32'(wrap_o[0]), 32'h0);
        wait_cnt(0, 16'h0000, "bin wrap up");
        check("wrap up pulse", 32'(wrap_o[0]), 32'h1);
        up_v[0] = 1'b0;
        @(negedge clk);
        check("wrap up one cycle", 32'(wrap_o[0]), 32'h0);
        wait_cnt(0, 16'hFFFF, "bin wrap down");
        check("wrap down pulse", 32'(wrap_o[0]), 32'h1);

        // Load lands on the step cycle: load wins, next step four cycles later
        up_v[0] = 1'b1;
        repeat (3) @(negedge clk);
        load_v[0] = 1'b1; lv[0] = 16'h1234;
        @(negedge clk);
        load_v[0] = 1'b0;
        check("load vs step", 32'(cnt_o[0]), 32'h1234);
        check("load vs step wrap", 32'(wrap_o[0]), 32'h0);
        repeat (3) @(negedge clk);
        check("post load hold", 32'(cnt_o[0]), 32'h1234);
        @(negedge clk);
        check("post load step", 32'(cnt_o[0]), 32'h1235);

        // Freeze: count holds, scan keeps cycling
        en_v[0] = 1'b0;
        seen = '0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("frozen count", 32'(cnt_o[0]), 32'h1235);
            case (an_o[0])
                4'hE: begin seen[0] = 1'b1; check("frozen digit0", 32'(cat_o[0]), 32'h92); end
                4'hD: begin seen[1] = 1'b1; check("frozen digit1", 32'(cat_o[0]), 32'hB0); end
                4'hB: begin seen[2] = 1'b1; check("frozen digit2", 32'(cat_o[0]), 32'hA4); end
                4'h7: begin seen[3] = 1'b1; check("frozen digit3", 32'(cat_o[0]), 32'hF9); end
                default: check("frozen anode onehot", 32'(an_o[0]), 32'hE);
            endcase
        end
        check("all digits scanned", 32'(seen), 32'hF);

        // BCD ripple, borrow, wrap and clamp
        en_v[1] = 1'b1; up_v[1] = 1'b1;
        load_v[1] = 1'b1; lv[1] = 16'h0099;
        @(negedge clk);
        load_v[1] = 1'b0;
        wait_cnt(1, 16'h0100, "bcd ripple");
        check("bcd ripple no wrap", 32'(wrap_o[1]), 32'h0);
        up_v[1] = 1'b0;
        wait_cnt(1, 16'h0099, "bcd borrow");
        up_v[1] = 1'b1;
        load_v[1] = 1'b1; lv[1] = 16'h9999;
        @(negedge clk);
        load_v[1] = 1'b0;
        check("bcd load 9999", 32'(cnt_o[1]), 32'h9999);
        wait_cnt(1, 16'h0000, "bcd wrap");
        check("bcd wrap pulse", 32'(wrap_o[1]), 32'h1);
        en_v[1] = 1'b0;
        load_v[1] = 1'b1; lv[1] = 16'h00AF;
        @(negedge clk);
        load_v[1] = 1'b0;
        check("bcd clamp", 32'(cnt_o[1]), 32'h0099);

        // Asynchronous reset in the middle of the low clock phase
        load_v[0] = 1'b1; lv[0] = 16'h0057; en_v[0] = 1'b1;
        @(negedge clk);
        load_v[0] = 1'b0;
        check("pre reset count", 32'(cnt_o[0]), 32'h0057);
        #2 switch = 1'b0;
        #1;
        check("async count",   32'(cnt_o[0]), 32'h0);
        check("async anode",   32'(an_o[0]),  32'hF);
        check("async cathode", 32'(cat_o[0]), 32'hFF);
        check("bcd async count", 32'(cnt_o[1]), 32'h0);
        repeat (2) @(negedge clk);
        switch = 1'b1;
        repeat (6) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
